// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the packet-atomic N:1 stream multiplexer.
// The slice helper works on a bus padded to the widest legal configuration.
package stream_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int MAX_CH  = 16;
    localparam int MAX_W   = 64;
    localparam int MAX_BUS = MAX_CH * MAX_W;

    // Returns channel idx of a bus of width-bit lanes, LSB-aligned; the caller truncates.
    function automatic logic [MAX_W-1:0] slice_at(
        input logic [MAX_BUS-1:0] bus,
        input int unsigned        idx,
        input int unsigned        width
    );
        logic [MAX_BUS-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/stream_reg.sv
// Single-stage valid/ready register slice carrying data plus an end-of-packet flag.
// Accepts a new beat whenever the slot is empty or being drained this cycle.
module stream_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too so the output bus is known after reset,
            // even though out_valid alone qualifies it.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_last  <= in_last;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 stream multiplexer that locks onto one channel for a whole packet.
// Selection happens only in IDLE, costing one bubble cycle per packet.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [SEL_W-1:0]      cur_sel
);

    state_t             state;
    logic [SEL_W-1:0]   cur_sel_q;
    logic               sel_ok;
    logic               lock_valid;
    logic               reg_ready;
    logic               xfer;
    logic [WIDTH-1:0]   sel_data;
    logic [MAX_BUS-1:0] bus_ext;

    // Out-of-range selects exist only when N_CH is not a power of two.
    assign sel_ok     = int'(sel) < N_CH;
    assign lock_valid = (state == LOCK) && in_valid[cur_sel_q];
    assign xfer       = lock_valid && reg_ready && !rst;

    always_comb begin
        bus_ext                   = '0;
        bus_ext[N_CH*WIDTH-1:0]   = in_data;
    end

    assign sel_data = WIDTH'(slice_at(bus_ext, int'(cur_sel_q), WIDTH));

    always_comb begin
        // NOTE: every bit gets a default before the conditional write, so no latch is inferred.
        in_ready = '0;
        if (state == LOCK && !rst) begin
            in_ready[cur_sel_q] = reg_ready;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state     <= IDLE;
            cur_sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_ok && in_valid[sel]) begin
                        cur_sel_q <= sel;
                        state     <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer && in_last[cur_sel_q]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == LOCK);
    assign cur_sel = cur_sel_q;

    stream_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_data  (sel_data),
        .in_valid (lock_valid),
        .in_last  (in_last[cur_sel_q]),
        .in_ready (reg_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_stream_mux_n.sv
// Randomised scoreboard bench for stream_mux_n: per-channel packet sources,
// a packet-level ownership model and an output monitor popping expected beats.
module tb_stream_mux_n;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int SW        = 2;
    localparam int SRC_DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic           busy;
    logic [SW-1:0]  cur_sel;

    logic           rst3;
    logic [1:0]     sel3;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_last3;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_last3;
    logic           out_ready3;
    logic           busy3;
    logic [1:0]     cur_sel3;

    always #5 clk = ~clk;

    stream_mux_n #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .cur_sel(cur_sel)
    );

    stream_mux_n #(.N_CH(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst(rst3), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
        .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_last(out_last3), .out_ready(out_ready3), .busy(busy3), .cur_sel(cur_sel3)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t src_mem [N][SRC_DEPTH];
    int    src_head [N];
    int    src_tail [N];
    beat_t exp_q [$];

    int checks = 0;
    int errors = 0;

    // Packet-level view: which channel owns the output, and whether a beat sits in the output slot.
    int            owner = -1;
    logic [SW-1:0] m_cur = '0;
    bit            m_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pending(input int ch);
        return src_tail[ch] - src_head[ch];
    endfunction

    task automatic push_beat(input int ch, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_mem[ch][src_tail[ch]] = b;
        src_tail[ch]++;
    endtask

    task automatic push_packet(input int ch, input int len);
        for (int i = 0; i < len; i++) begin
            push_beat(ch, W'($urandom), (i == len - 1));
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
    task automatic step(input logic [SW-1:0] s, input bit rdy, input bit r, input int vpct);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc;
        rst       = r;
        sel       = s;
        out_ready = rdy;
        for (int ch = 0; ch < N; ch++) begin
            if (pending(ch) > 0 && $urandom_range(99) < vpct) begin
                in_valid[ch]       = 1'b1;
                in_data[ch*W +: W] = src_mem[ch][src_head[ch]].data;
                in_last[ch]        = src_mem[ch][src_head[ch]].last;
            end else begin
                in_valid[ch]       = 1'b0;
                in_data[ch*W +: W] = W'($urandom);
                in_last[ch]        = 1'($urandom);
            end
        end
        @(negedge clk);
        exp_rdy = '0;
        if (!r && owner >= 0 && (!m_ov || rdy)) exp_rdy[owner] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(owner >= 0));
        check("cur_sel", 64'(cur_sel), 64'(m_cur));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        acc = in_valid & exp_rdy;
        for (int ch = 0; ch < N; ch++) begin
            if (acc[ch]) begin
                exp_q.push_back(src_mem[ch][src_head[ch]]);
                src_head[ch]++;
            end
        end
        @(posedge clk);
        if (r) begin
            owner = -1;
            m_cur = '0;
            m_ov  = 1'b0;
            exp_q.delete();
        end else if (owner >= 0) begin
            if (acc != '0) begin
                m_ov = 1'b1;
                if (in_last[owner]) owner = -1;
            end else if (rdy) begin
                m_ov = 1'b0;
            end
        end else begin
            if (rdy) m_ov = 1'b0;
            if (int'(s) < N && in_valid[s]) begin
                owner = int'(s);
                m_cur = s;
            end
        end
        #1;
    endtask

    // Output monitor: pops the expected beat on each downstream handshake, checks hold under stall.
    logic [W-1:0] held_data;
    logic         held_last;
    bit           stalled = 1'b0;
    beat_t        mon_beat;

    always @(negedge clk) begin
        if (stalled) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(held_data));
            check("hold_last", 64'(out_last), 64'(held_last));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_beat: got data %0h last %0b with no beat expected at %0t",
                         out_data, out_last, $time);
            end else begin
                mon_beat = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(mon_beat.data));
                check("out_last", 64'(out_last), 64'(mon_beat.last));
            end
        end
        stalled   = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
        held_data = out_data;
        held_last = out_last;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        rst       = 1'b1;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        for (int ch = 0; ch < N; ch++) begin
            src_head[ch] = 0;
            src_tail[ch] = 0;
        end

        // Three-channel instance: an out-of-range select never locks.
        rst3       = 1'b1;
        sel3       = 2'd0;
        in_data3   = 24'h33_22_11;
        in_valid3  = 3'b000;
        in_last3   = 3'b000;
        out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst3      = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        repeat (4) begin
            @(negedge clk);
            check("n3_in_ready", 64'(in_ready3), 64'(0));
            check("n3_out_valid", 64'(out_valid3), 64'(0));
            check("n3_busy", 64'(busy3), 64'(0));
        end
        sel3 = 2'd2;
        @(negedge clk);
        check("n3_lock_busy", 64'(busy3), 64'(1));
        check("n3_lock_sel", 64'(cur_sel3), 64'(2));
        check("n3_lock_ready", 64'(in_ready3), 64'(3'b100));

        @(posedge clk);
        #1;
        repeat (4) step(2'd0, 1'b1, 1'b0, 0);

        // Three-beat packet on channel 2 at full rate.
        push_beat(2, 8'hA1, 1'b0);
        push_beat(2, 8'hA2, 1'b0);
        push_beat(2, 8'hA3, 1'b1);
        repeat (6) step(2'd2, 1'b1, 1'b0, 100);

        // Backpressure for three cycles in the middle of a packet.
        push_beat(2, 8'hB1, 1'b0);
        push_beat(2, 8'hB2, 1'b0);
        push_beat(2, 8'hB3, 1'b0);
        push_beat(2, 8'hB4, 1'b1);
        repeat (3) step(2'd2, 1'b1, 1'b0, 100);
        repeat (3) step(2'd2, 1'b0, 1'b0, 100);
        repeat (5) step(2'd2, 1'b1, 1'b0, 100);

        // Select moves to channel 1 while channel 2 is mid-packet.
        push_beat(2, 8'hC1, 1'b0);
        push_beat(2, 8'hC2, 1'b0);
        push_beat(2, 8'hC3, 1'b0);
        push_beat(2, 8'hC4, 1'b1);
        push_beat(1, 8'hD1, 1'b0);
        push_beat(1, 8'hD2, 1'b1);
        repeat (2) step(2'd2, 1'b1, 1'b0, 100);
        repeat (12) step(2'd1, 1'b1, 1'b0, 100);

        // Reset after the first beat of four; the rest forms a new packet.
        push_beat(3, 8'hE1, 1'b0);
        push_beat(3, 8'hE2, 1'b0);
        push_beat(3, 8'hE3, 1'b0);
        push_beat(3, 8'hE4, 1'b1);
        repeat (2) step(2'd3, 1'b1, 1'b0, 100);
        step(2'd3, 1'b0, 1'b1, 100);
        repeat (8) step(2'd3, 1'b1, 1'b0, 100);

        // Random traffic, stalls, select churn and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (pending(ch) < 2 && $urandom_range(3) == 0) begin
                    push_packet(ch, int'($urandom_range(5, 1)));
                end
            end
            step(SW'($urandom_range(N - 1)), ($urandom_range(99) < 75),
                 ($urandom_range(199) == 0), 75);
        end

        // Drain every source at full rate.
        for (int c = 0; c < 400; c++) begin
            logic [SW-1:0] s;
            total = 0;
            s     = '0;
            for (int ch = 0; ch < N; ch++) begin
                total += pending(ch);
                if (pending(ch) > 0) s = SW'(ch);
            end
            if (total == 0) break;
            step(s, 1'b1, 1'b0, 100);
        end
        repeat (3) step(2'd0, 1'b1, 1'b0, 0);

        total = 0;
        for (int ch = 0; ch < N; ch++) total += pending(ch);
        check("drain_sources", 64'(total), 64'(0));
        check("drain_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-to-1 streaming multiplexer. It generalises the team's 2:1 combinational mux primitive to N channels of WIDTH bits.
- Adds valid/ready/last handshaking, a registered output stage, and packet-atomic select: the channel switches only at packet boundaries, so packets are never interleaved.
- Sits between multiple packet producers and a single consumer, for example a shared transmit path.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data bits per beat (1..64).
- SEL_W, $clog2(N_CH), select width; derived, must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- sel  in  SEL_W  requested channel; sampled only in IDLE.
- in_data  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel beat valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel ready.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_last  out  1  registered output last.
- out_ready  in  1  downstream ready.
- busy  out  1  high while state is LOCK.
- cur_sel  out  SEL_W  currently locked channel.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, cur_sel=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - in_ready is forced to all zeros while rst=1.
- States: IDLE, LOCK. busy = (state==LOCK).
- IDLE:
  - in_ready=0 for all channels.
  - If sel<N_CH and in_valid[sel]=1, then next cycle: cur_sel<=sel, state<=LOCK.
  - If sel>=N_CH (non-power-of-2 N_CH), stay in IDLE with no other effect.
  - Locking costs exactly one bubble cycle per packet.
- LOCK:
  - in_ready[cur_sel] = (!out_valid || out_ready). All other in_ready bits are 0.
  - Transfer occurs when in_valid[cur_sel] && in_ready[cur_sel].
  - On transfer: out_data<=in_data slice, out_last<=in_last[cur_sel], out_valid<=1.
  - On a transfer with in_last[cur_sel]=1: state<=IDLE.
  - sel changes during LOCK are ignored.
- Output register:
  - If out_valid && out_ready and no transfer this cycle, then out_valid<=0. out_data and out_last hold their last values.
  - While out_valid && !out_ready, out_data, out_last and out_valid hold stable.
- Latency and throughput:
  - An input beat appears on out_* one cycle after its transfer.
  - Sustains 1 beat/cycle within a packet while out_ready=1. in_ready depends combinationally on out_ready.
- Boundaries:
  - Single-beat packet (valid+last on the first beat): LOCK lasts one cycle, then IDLE.
  - Back-to-back packets on the same channel: one IDLE bubble between them.
  - Reset mid-packet: the output beat is discarded (out_valid=0). The remaining beats of that channel are treated as a new packet on the next lock; no other data is dropped.
  - in_valid deasserting mid-packet: remain in LOCK, no transfer.
- No combinational path from in_* to out_*. The only combinational path is out_ready to in_ready.

Decomposition:
- Package stream_mux_pkg holds:
  - state enum IDLE=1'b0, LOCK=1'b1;
  - a function that extracts a WIDTH slice given an index.
- Natural sub-module: stream_reg (a single-stage valid/ready output register with data+last), reusable elsewhere.
- The FSM and select logic remain in stream_mux_n.

Test Plan:
- Reset, then idle with all in_valid=0:
  - in_ready=0000, out_valid=0, busy=0, cur_sel=0.
- sel=2, ch2 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), out_ready=1:
  - busy rises one cycle after in_valid.
  - out_data shows A1,A2,A3 on consecutive cycles; out_last=1 only with A3.
  - Back to IDLE after A3.
- Backpressure: during the ch2 packet, hold out_ready=0 for 3 cycles:
  - in_ready[2]=0 while out_valid=1.
  - out_data held stable.
  - No beat lost or duplicated after release.
- Change sel from 2 to 1 mid-packet, with ch1 valid:
  - ch2 packet completes intact.
  - Only after ch2's last does the mux lock ch1 (cur_sel=1); ch1 data follows with no interleave.
- N_CH=3, sel=3 with all in_valid=1:
  - Stays IDLE, in_ready=000, out_valid=0.
- Assert rst for one cycle after beat 1 of 4:
  - out_valid=0, state IDLE, cur_sel=0 in the next cycle.
  - Re-lock then forwards the remaining beats with out_last on the 4th.
